// File: rtl/step_counter_pkg.sv
// Shared encodings for the lab step counter: counting modes and bounce direction.
package step_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/step_counter_fsm_if.sv
// Control/status bundle between the switch/button conditioning and the step counter.
interface step_counter_fsm_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             dir;
  logic             step2;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             wrap;
  logic             at_max;
  logic             at_min;
  logic             dir_state;

  // All controls are level signals sampled on clk; load is a one-cycle strobe.
  // There is no ready path: the counter accepts every control value on every edge.
  modport master (
    output en, dir, step2, mode, load, load_val,
    input  count, tick, wrap, at_max, at_min, dir_state
  );

  modport slave (
    input  en, dir, step2, mode, load, load_val,
    output count, tick, wrap, at_max, at_min, dir_state
  );
endinterface

// File: rtl/step_counter_fsm_tick_gen.sv
// Free-running divide-by-DIV enable: one registered clk-wide pulse every DIV cycles.
module tick_gen #(
  parameter int DIV = 3
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] pre_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
      tick  <= 1'b0;
    end else if (pre_q == LAST) begin
      pre_q <= '0;
      tick  <= 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
      tick  <= 1'b0;
    end
  end
endmodule

// File: rtl/step_counter_fsm.sv
// Prescaled up/down step counter with wrap, saturate, bounce and hold modes and a sync load.
module step_counter_fsm
  import step_counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DIV   = 3
) (
  input logic               clk,
  input logic               rst,
  step_counter_fsm_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic             tick;
  logic [WIDTH-1:0] count_q;
  dir_t             dir_q;
  logic             wrap_q;

  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH-1:0] nxt_count;
  dir_t             nxt_dir;
  logic             nxt_wrap;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // The extra top bit of up_sum/dn_diff is the carry/borrow out of the WIDTH-bit range.
  always_comb begin
    step_ext  = bus.step2 ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
    up_sum    = {1'b0, count_q} + step_ext;
    dn_diff   = {1'b0, count_q} - step_ext;
    nxt_count = count_q;
    nxt_dir   = dir_q;
    nxt_wrap  = 1'b0;
    case (mode_t'(bus.mode))
      MODE_WRAP: begin
        if (dir_t'(bus.dir) == DIR_UP) begin
          nxt_count = up_sum[WIDTH-1:0];
          nxt_wrap  = up_sum[WIDTH];
        end else begin
          nxt_count = dn_diff[WIDTH-1:0];
          nxt_wrap  = dn_diff[WIDTH];
        end
      end
      MODE_SAT: begin
        if (dir_t'(bus.dir) == DIR_UP)
          nxt_count = up_sum[WIDTH] ? MAX_COUNT : up_sum[WIDTH-1:0];
        else
          nxt_count = dn_diff[WIDTH] ? '0 : dn_diff[WIDTH-1:0];
      end
      MODE_BOUNCE: begin
        if (dir_q == DIR_UP) begin
          if (up_sum >= {1'b0, MAX_COUNT}) begin
            nxt_count = MAX_COUNT;
            nxt_dir   = DIR_DOWN;
            nxt_wrap  = 1'b1;
          end else begin
            nxt_count = up_sum[WIDTH-1:0];
          end
        end else begin
          if (dn_diff[WIDTH] || (dn_diff == '0)) begin
            nxt_count = '0;
            nxt_dir   = DIR_UP;
            nxt_wrap  = 1'b1;
          end else begin
            nxt_count = dn_diff[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= bus.load_val;
      dir_q   <= DIR_UP;
      wrap_q  <= 1'b0;
    end else if (tick && bus.en) begin
      count_q <= nxt_count;
      dir_q   <= nxt_dir;
      wrap_q  <= nxt_wrap;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign bus.count     = count_q;
  assign bus.tick      = tick;
  assign bus.wrap      = wrap_q;
  assign bus.at_max    = (count_q == MAX_COUNT);
  assign bus.at_min    = (count_q == '0);
  assign bus.dir_state = dir_q;
endmodule

// File: tb/tb_step_counter_fsm.sv
// Self-checking bench for step_counter_fsm (WIDTH=3, DIV=3) with a cycle model and expected queue.
module tb_step_counter_fsm;
  import step_counter_pkg::*;

  localparam int WIDTH = 3;
  localparam int DIV   = 3;
  localparam int MAXV  = (1 << WIDTH) - 1;
  localparam int EW    = WIDTH + 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [EW-1:0] exp_q[$];

  int m_pre, m_tick, m_count, m_dirq;

  step_counter_fsm_if #(.WIDTH(WIDTH)) bus ();

  step_counter_fsm #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_tick = 0; m_count = 0; m_dirq = 0;
  endtask

  // Advance the model by one edge using the inputs currently on the bus.
  task automatic model_step(output logic [EW-1:0] e);
    int c, s, w, tick_now;
    tick_now = m_tick;
    if (m_pre == DIV - 1) begin m_pre = 0; m_tick = 1; end
    else begin m_pre = m_pre + 1; m_tick = 0; end
    c = m_count;
    s = bus.step2 ? 2 : 1;
    w = 0;
    if (bus.load) begin
      c = int'(bus.load_val);
      m_dirq = 0;
    end else if (tick_now == 1 && bus.en) begin
      case (bus.mode)
        2'b00: begin
          if (!bus.dir) begin c = c + s; if (c > MAXV) begin c = c - (MAXV + 1); w = 1; end end
          else begin c = c - s; if (c < 0) begin c = c + (MAXV + 1); w = 1; end end
        end
        2'b01: begin
          if (!bus.dir) begin c = c + s; if (c > MAXV) c = MAXV; end
          else begin c = c - s; if (c < 0) c = 0; end
        end
        2'b10: begin
          if (m_dirq == 0) begin
            if (c + s >= MAXV) begin c = MAXV; m_dirq = 1; w = 1; end
            else c = c + s;
          end else begin
            if (c - s <= 0) begin c = 0; m_dirq = 0; w = 1; end
            else c = c - s;
          end
        end
        default: ;
      endcase
    end
    m_count = c;
    e = {WIDTH'(m_count), 1'(m_tick), 1'(w)};
  endtask

  task automatic cyc();
    logic [EW-1:0] e, got_e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    check_eq("count", int'(bus.count), int'(got_e[EW-1:2]));
    check_eq("tick", int'(bus.tick), int'(got_e[1]));
    check_eq("wrap", int'(bus.wrap), int'(got_e[0]));
    check_eq("at_max", int'(bus.at_max), int'(got_e[EW-1:2] == WIDTH'(MAXV)));
    check_eq("at_min", int'(bus.at_min), int'(got_e[EW-1:2] == '0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input int v);
    bus.load = 1'b1;
    bus.load_val = WIDTH'(v);
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic set_ctl(input logic en, input logic dir, input logic step2, input logic [1:0] mode);
    bus.en = en; bus.dir = dir; bus.step2 = step2; bus.mode = mode;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.load = 1'b0;
    bus.load_val = '0;
    set_ctl(1'b1, 1'b0, 1'b0, MODE_WRAP);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_count", int'(bus.count), 0);
    check_eq("reset_tick", int'(bus.tick), 0);
    check_eq("reset_wrap", int'(bus.wrap), 0);
    check_eq("reset_at_min", int'(bus.at_min), 1);
    #3 rst = 1'b1;

    // 1: full up-count cycle through the wrap.
    run(3 * 9 + 2);

    // 2: wrap mode down and step-2 boundary crossings.
    do_load(0);
    set_ctl(1'b1, 1'b1, 1'b0, MODE_WRAP);
    run(6);
    do_load(6);
    set_ctl(1'b1, 1'b0, 1'b1, MODE_WRAP);
    run(6);
    do_load(7);
    run(3);

    // 3: saturate at both ends.
    set_ctl(1'b1, 1'b0, 1'b1, MODE_SAT);
    do_load(5);
    run(9);
    do_load(1);
    set_ctl(1'b1, 1'b1, 1'b1, MODE_SAT);
    run(6);

    // 4: bounce with dir toggling underneath.
    set_ctl(1'b1, 1'b0, 1'b1, MODE_BOUNCE);
    do_load(5);
    for (int i = 0; i < 21; i++) begin
      bus.dir = ~bus.dir;
      cyc();
    end

    // 5: load coinciding with a tick, then async reset mid-count.
    set_ctl(1'b1, 1'b0, 1'b0, MODE_WRAP);
    for (int i = 0; i < DIV && m_tick == 0; i++) cyc();
    check_eq("tick_before_load", int'(bus.tick), 1);
    do_load(3);
    check_eq("load_on_tick", int'(bus.count), 3);
    run(4);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_count", int'(bus.count), 0);
    check_eq("async_rst_tick", int'(bus.tick), 0);
    model_reset();
    #2 rst = 1'b1;
    run(8);

    // 6: freeze with en=0 and with hold mode, then resume.
    bus.en = 1'b0;
    run(10);
    bus.en = 1'b1;
    run(6);
    bus.mode = MODE_HOLD;
    run(9);
    bus.mode = MODE_WRAP;
    run(6);

    // Random mix of all controls.
    for (int i = 0; i < 300; i++) begin
      bus.en    = ($urandom_range(0, 9) != 0);
      bus.dir   = 1'($urandom_range(0, 1));
      bus.step2 = 1'($urandom_range(0, 1));
      bus.mode  = 2'($urandom_range(0, 3));
      bus.load  = ($urandom_range(0, 19) == 0);
      bus.load_val = WIDTH'($urandom_range(0, MAXV));
      cyc();
    end
    bus.load = 1'b0;

    check_eq("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
